// File: rtl/pakin_pkg.sv
// Shared link sizing macros, channel-declaration helpers and derived constants for the
// packet receiver. Macros are guarded so every file of the link can pull them in.
`ifndef NS_GLOBAL_DEFS
`define NS_GLOBAL_DEFS
`define NS_ON 1
`define NS_OFF 0
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 4
`endif
`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 2
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 6
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`define NS_NUM_PACKETS(MSZ, PSZ) (((MSZ) + (PSZ) - 1) / (PSZ))
`define NS_DECLARE_PAKIN_CHNL(PAK, REQ, ACK) \
   logic [`NS_PACKET_SIZE-1:0] PAK; \
   logic REQ; \
   logic ACK;
`define NS_DECLARE_MSG_CHNL(ADDR, DATA, REQ, ACK) \
   logic [`NS_ADDRESS_SIZE-1:0] ADDR; \
   logic [`NS_DATA_SIZE-1:0] DATA; \
   logic REQ; \
   logic ACK;
`endif

package pakin_pkg;
   localparam int PSZ  = `NS_PACKET_SIZE;
   localparam int FSZ  = `NS_MESSAGE_FIFO_SIZE;
   localparam int ASZ  = `NS_ADDRESS_SIZE;
   localparam int DSZ  = `NS_DATA_SIZE;
   localparam int MSZ  = ASZ + DSZ;
   localparam int NPK  = `NS_NUM_PACKETS(MSZ, PSZ);
   localparam int PKW  = NPK * PSZ;
   localparam int IDXW = (NPK > 1) ? $clog2(NPK) : 1;

   // Address sits in the upper bits, data in the LSBs, matching {addr, data}.
   typedef struct packed {
      logic [ASZ-1:0] addr;
      logic [DSZ-1:0] data;
   } msg_t;

   function automatic msg_t to_msg(input logic [MSZ-1:0] m);
      return msg_t'(m);
   endfunction
endpackage

// File: rtl/pakin_if.sv
// Packet-in and message-out four-phase channels of the receiver.
// slave is the receiver's view, master the link/cell side.
interface pakin_if;
   import pakin_pkg::*;

   logic [PSZ-1:0] rcv0_pak;
   logic           rcv0_req;
   logic           rcv0_ack;
   logic [ASZ-1:0] snd0_addr;
   logic [DSZ-1:0] snd0_data;
   logic           snd0_req;
   logic           snd0_ack;

   modport slave (
      input  rcv0_pak, rcv0_req, snd0_ack,
      output rcv0_ack, snd0_addr, snd0_data, snd0_req
   );

   modport master (
      output rcv0_pak, rcv0_req, snd0_ack,
      input  rcv0_ack, snd0_addr, snd0_data, snd0_req
   );
endinterface

// File: rtl/pakin_msg_fifo.sv
// Circular message FIFO (ns_msg_fifo); head word is visible combinationally so the
// consumer's output register performs the registered read.
module ns_msg_fifo #(
   parameter int W = 10,
   parameter int D = 2
) (
   input  logic         i_clk,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = (D > 1) ? $clog2(D) : 1;
   localparam int CW = $clog2(D + 1);

   logic [W-1:0]  mem [D];
   logic [AW-1:0] head_reg, head_next;
   logic [AW-1:0] tail_reg, tail_next;
   logic [CW-1:0] count_reg, count_next;
   logic          do_push, do_pop;

   assign full     = (count_reg == CW'(D));
   assign empty    = (count_reg == '0);
   // A push into a full FIFO is fine when the same edge pops.
   assign do_push  = push && (!full || pop);
   assign do_pop   = pop && !empty;
   assign pop_data = mem[head_reg];

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (do_push) tail_next = (tail_reg == AW'(D - 1)) ? '0 : tail_reg + AW'(1);
      if (do_pop)  head_next = (head_reg == AW'(D - 1)) ? '0 : head_reg + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (clr) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push) mem[tail_reg] <= push_data;
   end
endmodule

// File: rtl/pakin.sv
// Packet receiver: reassembles PSZ-bit packets into address+data messages and sends them out.
// Optional NS_PAKIN_MSG_COUNT_EN adds a dbg_msg_cnt port counting delivered messages.
module pakin
   import pakin_pkg::*;
(
   input  logic        i_clk,
   input  logic        reset,
   output logic        ready,
`ifdef NS_PAKIN_MSG_COUNT_EN
   output logic [15:0] dbg_msg_cnt,
`endif
   pakin_if.slave      lnk
);
   logic            ready_reg;
   logic            clr;
   logic [IDXW-1:0] pk_idx_reg, pk_idx_next;
   logic [PKW-1:0]  asm_reg, asm_next;
   logic            rcv_ack_reg, rcv_ack_next;
   logic            snd_req_reg, snd_req_next;
   msg_t            snd_msg_reg, snd_msg_next;
   logic            last_pk, pak_accept, msg_push, msg_load, snd_done;
   logic            fifo_full, fifo_empty;
   logic [MSZ-1:0]  fifo_rdata;

   // Both reset and the init edge wipe every piece of state.
   assign clr        = !reset || !ready_reg;
   assign last_pk    = (pk_idx_reg == IDXW'(NPK - 1));
   assign pak_accept = ready_reg && lnk.rcv0_req && !rcv_ack_reg && !(last_pk && fifo_full);
   assign msg_push   = pak_accept && last_pk;
   assign msg_load   = ready_reg && !snd_req_reg && !lnk.snd0_ack && !fifo_empty;
   assign snd_done   = ready_reg && snd_req_reg && lnk.snd0_ack;

   genvar gi;
   generate
      for (gi = 0; gi < NPK; gi++) begin : g_slot
         assign asm_next[gi*PSZ +: PSZ] = (pak_accept && pk_idx_reg == IDXW'(gi))
                                        ? lnk.rcv0_pak : asm_reg[gi*PSZ +: PSZ];
      end
   endgenerate

   always_comb begin
      pk_idx_next  = pk_idx_reg;
      rcv_ack_next = rcv_ack_reg;
      snd_req_next = snd_req_reg;
      snd_msg_next = snd_msg_reg;
      if (pak_accept) begin
         pk_idx_next  = last_pk ? '0 : pk_idx_reg + IDXW'(1);
         rcv_ack_next = 1'b1;
      end else if (!lnk.rcv0_req) begin
         rcv_ack_next = 1'b0;
      end
      if (msg_load) begin
         snd_req_next = 1'b1;
         snd_msg_next = to_msg(fifo_rdata);
      end else if (snd_done) begin
         snd_req_next = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (clr) begin
         ready_reg   <= reset;
         pk_idx_reg  <= '0;
         asm_reg     <= '0;
         rcv_ack_reg <= 1'b0;
         snd_req_reg <= 1'b0;
         snd_msg_reg <= '0;
      end else begin
         pk_idx_reg  <= pk_idx_next;
         asm_reg     <= asm_next;
         rcv_ack_reg <= rcv_ack_next;
         snd_req_reg <= snd_req_next;
         snd_msg_reg <= snd_msg_next;
      end
   end

   // The last packet goes straight into the FIFO alongside the already-latched slots.
   ns_msg_fifo #(
      .W (MSZ),
      .D (FSZ)
   ) u_fifo (
      .i_clk     (i_clk),
      .clr       (clr),
      .push      (msg_push),
      .push_data (asm_next[MSZ-1:0]),
      .pop       (msg_load),
      .pop_data  (fifo_rdata),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign ready         = ready_reg;
   assign lnk.rcv0_ack  = rcv_ack_reg;
   assign lnk.snd0_req  = snd_req_reg;
   assign lnk.snd0_addr = snd_msg_reg.addr;
   assign lnk.snd0_data = snd_msg_reg.data;

`ifdef NS_PAKIN_MSG_COUNT_EN
   logic [15:0] msg_cnt_reg;

   always_ff @(posedge i_clk) begin
      if (clr)           msg_cnt_reg <= '0;
      else if (snd_done) msg_cnt_reg <= msg_cnt_reg + 16'd1;
   end

   assign dbg_msg_cnt = msg_cnt_reg;
`else
   // Message counter not built in this configuration.
`endif
endmodule
